// File: rtl/uart_test_pkg.sv
// Shared types and constants for the UART byte-echo self-test.
// Used by the initiator FSM and its pattern generator.
package uart_test_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t TERMINATOR = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_WAIT = 3'd1,
        ST_SEND      = 3'd2,
        ST_ECHO_WAIT = 3'd3,
        ST_FINISH    = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // The terminator value is reserved, so the data pattern steps over it.
    function automatic byte_t next_pattern(input byte_t cur);
        byte_t nxt;
        nxt = cur + 8'd1;
        if (nxt == TERMINATOR) begin
            nxt = TERMINATOR + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/echo_pattern_gen.sv
// Pattern register for the echo test: loads SEED, then steps +1 per byte,
// never producing the terminator value.
module echo_pattern_gen
    import uart_test_pkg::*;
#(
    parameter byte_t SEED = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] pattern
);

    byte_t pattern_q, pattern_d;

    always_comb begin
        pattern_d = pattern_q;
        if (load) begin
            pattern_d = SEED;
        end else if (advance) begin
            pattern_d = next_pattern(pattern_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_q <= SEED;
        end else begin
            pattern_q <= pattern_d;
        end
    end

    assign pattern = pattern_q;

endmodule

// File: rtl/echo_initiator.sv
// Initiator side of the UART byte-echo link test: sends NUM_BYTES pattern
// bytes plus a terminator, checks every echo and reports pass/timeout/errors.
module echo_initiator
    import uart_test_pkg::*;
#(
    parameter int    NUM_BYTES      = 16,
    parameter byte_t SEED           = 8'h01,
    parameter int    TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       activate,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [7:0] error_count,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       rx_ready,
    input  logic [7:0] rx_data
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam byte_t            LAST_INDEX = byte_t'(NUM_BYTES);
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    byte_t            index_q, index_d;
    byte_t            tx_data_q, tx_data_d;
    byte_t            error_count_q, error_count_d;
    logic             timeout_q, timeout_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pat_load, pat_advance, err_inc;
    byte_t            pattern;

    // The byte-complete strobe is informational only; echo arrival drives progress.
    logic unused_tx_done;
    assign unused_tx_done = tx_done;

    echo_pattern_gen #(
        .SEED(SEED)
    ) u_pattern (
        .clk     (clk),
        .reset   (reset),
        .load    (pat_load),
        .advance (pat_advance),
        .pattern (pattern)
    );

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        tx_data_d     = tx_data_q;
        error_count_d = error_count_q;
        timeout_d     = timeout_q;
        pass_d        = pass_q;
        count_d       = count_q;
        pat_load      = 1'b0;
        pat_advance   = 1'b0;
        err_inc       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (activate) begin
                    error_count_d = 8'd0;
                    timeout_d     = 1'b0;
                    pass_d        = 1'b0;
                    index_d       = 8'd0;
                    pat_load      = 1'b1;
                    state_d       = ST_SEND_WAIT;
                end
            end
            ST_SEND_WAIT: begin
                err_inc = rx_ready;
                if (!tx_active) begin
                    tx_data_d = (index_q == LAST_INDEX) ? TERMINATOR : pattern;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                err_inc = rx_ready;
                count_d = '0;
                state_d = ST_ECHO_WAIT;
            end
            ST_ECHO_WAIT: begin
                // An echo landing on the final counter value still counts as arrived.
                if (rx_ready) begin
                    err_inc = (rx_data != tx_data_q);
                    if (index_q == LAST_INDEX) begin
                        state_d = ST_FINISH;
                    end else begin
                        index_d     = index_q + 8'd1;
                        pat_advance = 1'b1;
                        state_d     = ST_SEND_WAIT;
                    end
                end else if (count_q == CNT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FINISH;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            ST_FINISH: begin
                pass_d  = (error_count_q == 8'd0) && !timeout_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!activate) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (err_inc && (error_count_q != 8'hFF)) begin
            error_count_d = error_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            index_q       <= 8'd0;
            tx_data_q     <= 8'd0;
            error_count_q <= 8'd0;
            timeout_q     <= 1'b0;
            pass_q        <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            tx_data_q     <= tx_data_d;
            error_count_q <= error_count_d;
            timeout_q     <= timeout_d;
            pass_q        <= pass_d;
            count_q       <= count_d;
        end
    end

    assign done        = (state_q == ST_DONE);
    assign tx_start    = (state_q == ST_SEND);
    assign tx_data     = tx_data_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign error_count = error_count_q;

endmodule

// File: tb/tb_echo_initiator.sv
// Bench for echo_initiator: plays the responder's echo behaviour per scenario
// and compares byte order, timing and final results against a simple model.
module tb_echo_initiator;

    localparam int         NUM_BYTES      = 4;
    localparam logic [7:0] SEED           = 8'h53;
    localparam int         TIMEOUT_CYCLES = 50;
    localparam int         BUDGET         = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       activate;
    logic       done;
    logic       pass;
    logic       timeout;
    logic [7:0] error_count;
    logic       tx_active;
    logic       tx_done;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       rx_ready;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;
    int curScenario = -1;

    typedef struct {
        int busy;
        int strays;
        int delay;
        int corruptMask;
        int dropIdx;
        int dropAct;
        int expErr;
        int expPass;
        int expTimeout;
        int expTx;
    } vec_t;

    vec_t vectors [10];

    echo_initiator #(
        .NUM_BYTES      (NUM_BYTES),
        .SEED           (SEED),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .activate    (activate),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .error_count (error_count),
        .tx_active   (tx_active),
        .tx_done     (tx_done),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s (scenario %0d): got %0d (0x%0h) expected %0d (0x%0h)",
                     name, curScenario, actual, actual, expected, expected);
        end
    endtask

    // Byte i of the transmit sequence: SEED counting up mod 256 with 0x55
    // skipped, followed by the 0x55 terminator at position NUM_BYTES.
    function automatic int expectedByte(input int i);
        int p;
        if (i == NUM_BYTES) return 8'h55;
        p = SEED;
        for (int k = 0; k < i; k++) begin
            p = (p + 1) % 256;
            if (p == 8'h55) p = 8'h56;
        end
        return p;
    endfunction

    function automatic vec_t withModel(input vec_t v);
        vec_t r;
        int nEchoed;
        int bad;
        r = v;
        nEchoed = (v.dropIdx < 0) ? NUM_BYTES + 1 : v.dropIdx;
        bad = v.strays;
        for (int i = 0; i < nEchoed; i++) begin
            if (((v.corruptMask >> i) & 1) == 1) bad++;
        end
        r.expErr     = (bad > 255) ? 255 : bad;
        r.expTimeout = (v.dropIdx >= 0) ? 1 : 0;
        r.expTx      = (v.dropIdx >= 0) ? v.dropIdx + 1 : NUM_BYTES + 1;
        r.expPass    = (r.expErr == 0 && r.expTimeout == 0) ? 1 : 0;
        return r;
    endfunction

    // Starts at a falling edge with the DUT idle and activate low; ends the
    // same way after done has been released.
    task automatic applyStimulus(input vec_t v);
        int cyc, sent, echoAt, expNextStart, sawTimeoutAt, expTimeoutAt, expDoneAt, doneAt;
        bit echoPending, finished;
        logic [7:0] echoByte;
        cyc = 0; sent = 0; echoAt = -1; echoPending = 0; finished = 0; echoByte = 8'h00;
        sawTimeoutAt = -1; expTimeoutAt = -1; expDoneAt = -1; doneAt = -1;
        expNextStart = (v.busy + 1 > 2) ? v.busy + 1 : 2;
        while (cyc < BUDGET && !finished) begin
            if (tx_start) begin
                if (sent <= NUM_BYTES) begin
                    checkOutput("txData", int'(tx_data), expectedByte(sent));
                    checkOutput("txStartCycle", cyc, expNextStart);
                end else begin
                    checkOutput("extraTxStart", sent, NUM_BYTES);
                end
                if (sent == v.dropIdx) begin
                    expTimeoutAt = cyc + TIMEOUT_CYCLES + 1;
                    expDoneAt    = expTimeoutAt + 1;
                end else begin
                    echoPending = 1;
                    echoAt      = cyc + v.delay;
                    echoByte    = (((v.corruptMask >> sent) & 1) == 1) ? 8'hFF : 8'(expectedByte(sent));
                end
                sent++;
            end
            if (cyc >= 1 && timeout && sawTimeoutAt < 0) sawTimeoutAt = cyc;
            if (done) begin
                finished = 1;
                doneAt   = cyc;
            end else begin
                activate  = (v.dropAct != 0 && sent > 0) ? 1'b0 : 1'b1;
                tx_active = (cyc < v.busy);
                tx_done   = 1'($urandom_range(0, 1));
                rx_ready  = 1'b0;
                rx_data   = 8'($urandom);
                if (echoPending && cyc == echoAt) begin
                    rx_ready     = 1'b1;
                    rx_data      = echoByte;
                    echoPending  = 0;
                    expNextStart = cyc + 2;
                    if (sent == NUM_BYTES + 1) expDoneAt = cyc + 2;
                end else if (cyc >= 1 && cyc <= v.strays) begin
                    rx_ready = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) begin
            checkOutput("doneWithinBudget", 0, 1);
            reset = 1'b1; activate = 1'b0; rx_ready = 1'b0; tx_active = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            return;
        end
        checkOutput("txCount", sent, v.expTx);
        checkOutput("pass", int'(pass), v.expPass);
        checkOutput("timeout", int'(timeout), v.expTimeout);
        checkOutput("errorCount", int'(error_count), v.expErr);
        checkOutput("doneCycle", doneAt, expDoneAt);
        if (v.expTimeout != 0) checkOutput("timeoutCycle", sawTimeoutAt, expTimeoutAt);
        activate = 1'b0; rx_ready = 1'b0; tx_active = 1'b0;
        @(negedge clk);
        checkOutput("doneCleared", int'(done), 0);
        checkOutput("passHeldIdle", int'(pass), v.expPass);
        checkOutput("errorHeldIdle", int'(error_count), v.expErr);
    endtask

    task automatic waitTxStart(output int found);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (tx_start) found = 1;
            else @(negedge clk);
        end
        if (found == 0) checkOutput("txStartWithinBudget", 0, 1);
    endtask

    initial begin
        int found;
        vec_t v;

        //                 busy strays delay mask drop dAct  err pass to tx
        vectors[0] = '{   0,   0,   20,    0,  -1,  0,    0,  1,  0,  5};
        vectors[1] = '{   0,   0,   20,    6,  -1,  0,    2,  0,  0,  5};
        vectors[2] = '{   0,   0,   20,    0,   2,  0,    0,  0,  1,  3};
        vectors[3] = '{  30,   1,   20,    0,  -1,  0,    1,  0,  0,  5};
        vectors[4] = '{   0,   0,   50,    0,  -1,  0,    0,  1,  0,  5};
        vectors[5] = '{   0,   0,    1,    0,  -1,  0,    0,  1,  0,  5};
        vectors[6] = '{ 300, 280,    7,   31,  -1,  0,  255,  0,  0,  5};
        vectors[7] = '{   0,   0,   20,    0,  -1,  1,    0,  1,  0,  5};
        vectors[8] = '{   0,   0,   10,    1,   4,  0,    1,  0,  1,  5};
        vectors[9] = '{   5,   0,   13,   16,  -1,  0,    1,  0,  0,  5};

        reset = 1'b1; activate = 1'b0; tx_active = 1'b0; tx_done = 1'b0;
        rx_ready = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstPass", int'(pass), 0);
        checkOutput("rstTimeout", int'(timeout), 0);
        checkOutput("rstErrorCount", int'(error_count), 0);
        checkOutput("rstTxStart", int'(tx_start), 0);
        checkOutput("rstTxData", int'(tx_data), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            curScenario = i;
            applyStimulus(vectors[i]);
        end

        // Reset while waiting for the echo of byte 2, with one bad echo banked.
        curScenario = 100;
        activate = 1'b1;
        waitTxStart(found);
        checkOutput("rstSeqByte1", int'(tx_data), int'(SEED));
        repeat (4) @(negedge clk);
        rx_ready = 1'b1; rx_data = 8'hFF;
        @(negedge clk);
        rx_ready = 1'b0;
        waitTxStart(found);
        checkOutput("rstSeqByte2", int'(tx_data), expectedByte(1));
        repeat (3) @(negedge clk);
        checkOutput("rstSeqErrBefore", int'(error_count), 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRstDone", int'(done), 0);
        checkOutput("midRstPass", int'(pass), 0);
        checkOutput("midRstTimeout", int'(timeout), 0);
        checkOutput("midRstErrorCount", int'(error_count), 0);
        checkOutput("midRstTxStart", int'(tx_start), 0);
        checkOutput("midRstTxData", int'(tx_data), 0);
        reset = 1'b0; activate = 1'b0;
        @(negedge clk);
        curScenario = 101;
        applyStimulus(vectors[0]);

        for (int i = 0; i < 15; i++) begin
            curScenario = 200 + i;
            v.busy        = int'($urandom_range(0, 40));
            v.strays      = (v.busy >= 2) ? int'($urandom_range(0, v.busy - 1)) : 0;
            v.delay       = int'($urandom_range(1, TIMEOUT_CYCLES));
            v.corruptMask = int'($urandom_range(0, 31));
            v.dropIdx     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_BYTES)) : -1;
            v.dropAct     = int'($urandom_range(0, 1));
            v.expErr = 0; v.expPass = 0; v.expTimeout = 0; v.expTx = 0;
            applyStimulus(withModel(v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
